// File: rtl/seg_scan_if.sv
// seg_scan update port: load/capture request with busy/ack.
// Display outputs stay as plain ports on the scanner.
interface seg_scan_if;
  logic        load;
  logic [31:0] value;
  logic [7:0]  blank;
  logic        lzb;
  logic        busy;
  logic        ack;

  modport master (
    output load, value, blank, lzb,
    input  busy, ack
  );

  modport slave (
    input  load, value, blank, lzb,
    output busy, ack
  );
endinterface

// File: rtl/seg_scan.sv
// 8-digit multiplexed 7-seg scanner with frame-synchronous
// double-buffered updates and leading-zero blanking.
module seg_scan #(
  parameter int unsigned DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  seg_scan_if.slave  bus,
  output logic [3:0] seg_data,
  output logic       seg_flag,
  output logic [7:0] an
);

  localparam logic [15:0] LAST = 16'(DIV - 1);

  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [31:0] pv, av;
  logic [7:0]  pb, ab;
  logic        pz, az;
  logic        busy, ack;
  logic        tick, commit;
  logic [7:0]  zrun, blk;
  logic [3:0]  nib;

  assign tick     = en && (cnt == LAST);
  assign commit   = tick && (idx == 3'd7) && busy;
  assign bus.busy = busy;
  assign bus.ack  = ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (en) begin
      if (tick) begin
        cnt <= '0;
        idx <= idx + 3'd1;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  // commit reads the old pending copy before a same-cycle load replaces it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv   <= '0;
      pb   <= '0;
      pz   <= 1'b0;
      av   <= '0;
      ab   <= '0;
      az   <= 1'b0;
      busy <= 1'b0;
      ack  <= 1'b0;
    end else begin
      ack <= commit;
      if (commit) begin
        av <= pv;
        ab <= pb;
        az <= pz;
      end
      if (bus.load) begin
        pv   <= bus.value;
        pb   <= bus.blank;
        pz   <= bus.lzb;
        busy <= 1'b1;
      end else if (commit) begin
        busy <= 1'b0;
      end
    end
  end

  // zrun[i]: nibbles i..7 of the active value are all zero
  always_comb begin
    zrun = '0;
    for (int i = 0; i < 8; i++) begin
      zrun[i] = ((av >> (4 * i)) == 32'd0);
    end
    blk = ab | (az ? {zrun[7:1], 1'b0} : 8'h00);
    nib = av[{idx, 2'b00} +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_data <= '0;
      seg_flag <= 1'b0;
      an       <= 8'hFF;
    end else if (en) begin
      seg_data <= nib;
      seg_flag <= !blk[idx];
      an       <= ~(8'h01 << idx);
    end else begin
      seg_data <= '0;
      seg_flag <= 1'b0;
      an       <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: frame-level reference model, directed
// scenarios with literal expectations, then random traffic.
module tb_seg_scan;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [3:0] seg_data;
  logic       seg_flag;
  logic [7:0] an;

  seg_scan_if bus();

  seg_scan #(.DIV(DIV)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .bus(bus.slave),
    .seg_data(seg_data),
    .seg_flag(seg_flag),
    .an(an)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, a, e, $time);
    end
  endtask

  // reference model: digit position, count within digit, buffers
  int          m_cnt = 0;
  int          m_dig = 0;
  logic [31:0] m_pv = 0, m_av = 0;
  logic [7:0]  m_pb = 0, m_ab = 0;
  logic        m_pz = 0, m_az = 0;
  logic        m_busy = 0, m_ack = 0;
  logic [7:0]  m_an = 8'hFF;
  logic [3:0]  m_data = 0;
  logic        m_flag = 0;
  logic        m_tick, m_commit;

  function automatic logic dark(input logic [31:0] v,
                                input logic [7:0] b,
                                input logic z, input int i);
    return b[i] || (z && i > 0 && (v >> (4 * i)) == 32'd0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_dig = 0;
      m_pv = 0; m_pb = 0; m_pz = 0;
      m_av = 0; m_ab = 0; m_az = 0;
      m_busy = 0; m_ack = 0;
      m_an = 8'hFF; m_data = 0; m_flag = 0;
    end else begin
      if (en) begin
        m_an   = 8'hFF ^ (8'h01 << m_dig);
        m_data = 4'((m_av >> (4 * m_dig)) & 32'hF);
        m_flag = !dark(m_av, m_ab, m_az, m_dig);
      end else begin
        m_an = 8'hFF;
        m_flag = 0;
      end
      m_tick   = en && (m_cnt == DIV - 1);
      m_commit = m_tick && m_dig == 7 && m_busy;
      if (en) m_cnt = (m_cnt + 1) % DIV;
      if (m_tick) m_dig = (m_dig + 1) % 8;
      m_ack = m_commit;
      if (m_commit) begin
        m_av = m_pv; m_ab = m_pb; m_az = m_pz;
        m_busy = 0;
      end
      if (bus.load) begin
        m_pv = bus.value; m_pb = bus.blank; m_pz = bus.lzb;
        m_busy = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("an", {24'h0, an}, {24'h0, m_an});
      chk("flag", {31'h0, seg_flag}, {31'h0, m_flag});
      chk("busy", {31'h0, bus.busy}, {31'h0, m_busy});
      chk("ack", {31'h0, bus.ack}, {31'h0, m_ack});
      if (m_an != 8'hFF)
        chk("data", {28'h0, seg_data}, {28'h0, m_data});
    end
  end

  task automatic do_load(input logic [31:0] v, input logic [7:0] b,
                         input logic z);
    @(negedge clk); #1;
    bus.load = 1; bus.value = v; bus.blank = b; bus.lzb = z;
    @(negedge clk); #1;
    bus.load = 0;
  endtask

  task automatic wait_ack(input string nm);
    bit ok = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.ack) begin ok = 1; break; end
    end
    chk(nm, {31'h0, ok}, 32'h1);
  endtask

  logic [7:0] an_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7,
                             8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [3:0] d32 [8] = '{4'hF, 4'hE, 4'hD, 4'hC,
                          4'hB, 4'hA, 4'h9, 4'h8};
  logic       f33 [8] = '{1, 1, 1, 0, 0, 0, 0, 0};
  logic [3:0] d33 [3] = '{4'h0, 4'h2, 4'h1};

  initial begin
    int acks, sd, sc, held;
    bit found;
    bus.load = 0; bus.value = 0; bus.blank = 0; bus.lzb = 0;
    #2 rst_n = 0;
    #1;
    chk("rst an", {24'h0, an}, 32'hFF);
    chk("rst flag", {31'h0, seg_flag}, 0);
    chk("rst data", {28'h0, seg_data}, 0);
    chk("rst busy", {31'h0, bus.busy}, 0);
    chk("rst ack", {31'h0, bus.ack}, 0);
    @(negedge clk); @(negedge clk); #1;
    rst_n = 1; en = 1;
    @(negedge clk);
    chk("post rst an", {24'h0, an}, 32'hFE);
    chk("post rst flag", {31'h0, seg_flag}, 1);
    chk("post rst data", {28'h0, seg_data}, 0);

    do_load(32'h89AB_CDEF, 8'h00, 0);
    chk("load busy", {31'h0, bus.busy}, 1);
    wait_ack("ack32");
    for (int d = 0; d < 8; d++) begin
      @(negedge clk);
      chk("scan an", {24'h0, an}, {24'h0, an_tab[d]});
      chk("scan data", {28'h0, seg_data}, {28'h0, d32[d]});
      repeat (3) @(negedge clk);
    end

    do_load(32'h0000_0120, 8'h00, 1);
    wait_ack("ack33");
    for (int d = 0; d < 8; d++) begin
      @(negedge clk);
      chk("lzb an", {24'h0, an}, {24'h0, an_tab[d]});
      chk("lzb flag", {31'h0, seg_flag}, {31'h0, f33[d]});
      if (d < 3)
        chk("lzb data", {28'h0, seg_data}, {28'h0, d33[d]});
      repeat (3) @(negedge clk);
    end

    do_load(32'h1111_1111, 8'h00, 0);
    repeat (3) @(negedge clk);
    do_load(32'h2222_2222, 8'h00, 0);
    acks = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (bus.ack) acks++;
      if (acks == 1 && an != 8'hFF && !bus.ack)
        chk("two loads data", {28'h0, seg_data}, 32'h2);
    end
    chk("two loads acks", acks, 1);

    do_load(32'h0000_00A5, 8'h00, 0);
    found = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk); #1;
      if (m_dig == 7 && m_cnt == DIV - 1) begin found = 1; break; end
    end
    chk("find commit", {31'h0, found}, 1);
    bus.load = 1; bus.value = 32'h0000_005B;
    @(negedge clk);
    chk("c35 ack", {31'h0, bus.ack}, 1);
    chk("c35 busy", {31'h0, bus.busy}, 1);
    #1 bus.load = 0;
    @(negedge clk);
    chk("c35 first", {28'h0, seg_data}, 32'h5);
    wait_ack("ack35b");
    @(negedge clk);
    chk("c35 second", {28'h0, seg_data}, 32'hB);

    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (m_cnt == 1) begin found = 1; break; end
    end
    chk("find mid", {31'h0, found}, 1);
    sd = m_dig; sc = m_cnt;
    en = 0;
    @(negedge clk);
    chk("dark an", {24'h0, an}, 32'hFF);
    chk("dark flag", {31'h0, seg_flag}, 0);
    repeat (9) @(negedge clk);
    chk("frozen an", {24'h0, an}, 32'hFF);
    #1 en = 1;
    held = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (an == (8'hFF ^ (8'h01 << sd))) held++;
      else break;
    end
    chk("resume count", held, DIV - sc);

    do_load(32'hDEAD_BEEF, 8'h00, 0);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("ar an", {24'h0, an}, 32'hFF);
    chk("ar flag", {31'h0, seg_flag}, 0);
    chk("ar busy", {31'h0, bus.busy}, 0);
    chk("ar data", {28'h0, seg_data}, 0);
    @(negedge clk); #1;
    rst_n = 1;
    acks = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (bus.ack) acks++;
      if (an != 8'hFF)
        chk("ar zero", {28'h0, seg_data}, 0);
    end
    chk("ar acks", acks, 0);

    for (int i = 0; i < 800; i++) begin
      @(negedge clk); #1;
      en = ($urandom_range(0, 9) != 0);
      bus.load = ($urandom_range(0, 15) == 0);
      bus.value = $urandom >> (4 * $urandom_range(0, 7));
      bus.blank = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      bus.lzb = 1'($urandom);
    end
    @(negedge clk); #1;
    bus.load = 0; en = 1;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 SHALL provide parameter DIV, default 1000, clock cycles each digit is displayed (legal range 2..65535).
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL provide port en  input  1  scan enable; 0 = display dark, scanning frozen.
REQ-005 SHALL provide port load  input  1  single-cycle request to capture value/blank/lzb.
REQ-006 SHALL provide port value  input  32  eight hex nibbles; nibble i = value[4i+3:4i] drives digit i.
REQ-007 SHALL provide port blank  input  8  per-digit force-blank mask; bit i = 1 blanks digit i.
REQ-008 SHALL provide port lzb  input  1  leading-zero blanking enable.
REQ-009 SHALL provide port busy  output  1  a captured update is pending commit.
REQ-010 SHALL provide port ack  output  1  one-cycle pulse when a pending update is committed.
REQ-011 SHALL provide port seg_data  output  4  nibble for the downstream 7-segment decoder.
REQ-012 SHALL provide port seg_flag  output  1  decoder enable; 0 = decoder outputs all segments off.
REQ-013 SHALL provide port an  output  8  digit select, active-low, at most one bit low.

Function
REQ-014 SHALL hold a prescaler counting 0..DIV-1 while en=1; wrap from DIV-1 to 0 generates an internal tick.
REQ-015 SHALL advance digit index idx (3 bits) by 1 on each tick, wrapping 7 -> 0.
REQ-016 SHALL freeze prescaler and idx, without clearing them, while en=0.
REQ-017 SHALL capture value, blank, lzb into a pending register and set busy on any cycle with load=1.
REQ-018 SHALL let a load while busy=1 overwrite the pending register (last load wins); busy stays 1.
REQ-019 SHALL commit pending into the active register on the tick where idx wraps 7 -> 0 (frame boundary), only when busy=1.
REQ-020 SHALL on commit clear busy and pulse ack=1 for exactly one cycle.
REQ-021 SHALL, if load=1 in the same cycle as a commit, commit the previously pending contents and keep the new load pending with busy=1.
REQ-022 SHALL never change the active register other than at commit; no mid-frame tearing.
REQ-023 SHALL with lzb active: digit i (i=1..7) is blanked when active nibbles i..7 are all zero; digit 0 is never blanked by lzb.
REQ-024 SHALL blank digit i when active blank[i]=1 or lzb blanks it.
REQ-025 SHALL register outputs: one clock after idx takes value k, seg_data = active nibble k, an = all 1s except bit k = 0, seg_flag = not blanked(k).
REQ-026 SHALL drive an=8'hFF, seg_flag=0 one clock after en falls, and resume digit idx one clock after en rises.
REQ-027 SHALL drive seg_flag=0 while an bit is low for a blanked digit (digit still selected, segments dark).
REQ-028 SHALL keep busy/ack/load handling active when en=0; commit still waits for a frame-boundary tick.

Reset
REQ-029 SHALL on rst_n=0 immediately set prescaler=0, idx=0, pending/active registers=0, busy=0, ack=0, seg_data=0, seg_flag=0, an=8'hFF.
REQ-030 SHALL on rst_n deassertion with en=1 show digit 0 (an=8'hFE) one clock later with active value 0, seg_flag=1.
REQ-031 SHALL on reset mid-frame or with busy=1 discard the pending update; no ack is emitted for it.

Verification
REQ-032 SHALL cover: DIV=4, en=1, load value=32'h89ABCDEF, blank=0 -> busy=1, ack after first 7->0 wrap, then an cycles FE,FD,..,7F every 4 clocks with seg_data F,E,D,C,B,A,9,8.
REQ-033 SHALL cover: value=32'h0000_0120, lzb=1 -> digits 0..2 flag=1 (data 0,2,1), digits 3..7 seg_flag=0 with an still scanning.
REQ-034 SHALL cover: two loads (32'h1111_1111 then 32'h2222_2222) inside one frame -> single ack, all digits show 2.
REQ-035 SHALL cover: load on the exact commit cycle -> ack=1 that cycle, busy stays 1, second value committed at next frame boundary.
REQ-036 SHALL cover: en=0 for 10 clocks mid-digit -> an=8'hFF, idx/prescaler unchanged; on en=1 scanning resumes at same digit with remaining prescaler count.
REQ-037 SHALL cover: rst_n pulsed low asynchronously (between edges) while busy=1 -> outputs at reset values immediately, no ack, display shows zeros after release.
